pc_sequencer: RTL and testbench

Parametrised program counter for the ExceptioNull core: the next generation of the 8-bit increment/branch counter. It adds configurable width and reset vector, signed relative branches, absolute jumps, a hardware return-address stack (RAS) for call/return, a stall input and sticky stack-fault flags. It sits at the head of the fetch path: `pc` addresses instruction memory, and the decode stage drives `op`, `cond`, `offset` and `target`.

---
 rtl/pc_sequencer.sv | 116 +++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter with increment, signed relative branch, absolute jump and call/return.
// Define PC_RAS_EN to build the return-address stack; otherwise CALL acts as JMP and RET as INC.
module pc_sequencer #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [2:0]                         op,
  input  logic                               cond,
  input  logic [PC_W-1:0]                    offset,
  input  logic [PC_W-1:0]                    target,
  input  logic                               clr_flags,
  output logic [PC_W-1:0]                    pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_cnt,
  output logic                               ras_ovf,
  output logic                               ras_unf
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  typedef enum logic [2:0] {
    OP_INC  = 3'b000,
    OP_BR   = 3'b001,
    OP_JMP  = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100
  } op_e;

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_ras_top;
  logic            w_ras_empty;

  assign w_seq = r_pc + PC_W'(1);

  // Adding the offset at full width wraps modulo 2^PC_W, which equals sign extension.
  always_comb begin
    w_pc_nxt = w_seq;
    case (op)
      OP_BR:           if (cond) w_pc_nxt = w_seq + offset;
      OP_JMP, OP_CALL: w_pc_nxt = target;
      OP_RET:          if (!w_ras_empty) w_pc_nxt = w_ras_top;
      default:         w_pc_nxt = w_seq;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_pc <= RESET_VEC;
    else if (en) r_pc <= w_pc_nxt;
  end

  assign pc = r_pc;

`ifdef PC_RAS_EN
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [PC_W-1:0]  r_ras [RAS_DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_unf;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [IDX_W-1:0] w_push_idx;
  logic [IDX_W-1:0] w_top_idx;

  assign w_ras_empty = (r_cnt == '0);
  assign w_full      = (r_cnt == CNT_W'(RAS_DEPTH));
  assign w_push      = en && (op == OP_CALL) && !w_full;
  assign w_pop       = en && (op == OP_RET) && !w_ras_empty;
  assign w_push_idx  = IDX_W'(r_cnt);
  assign w_top_idx   = IDX_W'(r_cnt - CNT_W'(1));
  assign w_ras_top   = r_ras[w_top_idx];

  // Stack contents need no reset: ras_cnt alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_ras[w_push_idx] <= w_seq;
  end

  // A fault raised on the same edge as clr_flags overrides the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (clr_flags) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end
      if (en && (op == OP_CALL) && w_full)       r_ovf <= 1'b1;
      if (en && (op == OP_RET) && w_ras_empty)   r_unf <= 1'b1;
      if (w_push)                                r_cnt <= r_cnt + CNT_W'(1);
      else if (w_pop)                            r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign ras_cnt = r_cnt;
  assign ras_ovf = r_ovf;
  assign ras_unf = r_unf;
`else
  logic w_unused;

  assign w_ras_empty = 1'b1;
  assign w_ras_top   = '0;
  assign ras_cnt     = '0;
  assign ras_ovf     = 1'b0;
  assign ras_unf     = 1'b0;
  assign w_unused    = clr_flags;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed test-plan steps followed by random operations,
// all checked against a queue-based reference model (follows PC_RAS_EN like the design).
module tb_pc_sequencer;

  localparam int         PC_W      = 8;
  localparam logic [7:0] RESET_VEC = 8'h10;
  localparam int         RAS_DEPTH = 2;

`ifdef PC_RAS_EN
  localparam bit HAS_RAS = 1'b1;
`else
  localparam bit HAS_RAS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] op = 3'd0;
  logic       cond = 1'b0;
  logic [7:0] offset = 8'h00;
  logic [7:0] target = 8'h00;
  logic       clr_flags = 1'b0;
  logic [7:0] pc;
  logic [1:0] ras_cnt;
  logic       ras_ovf;
  logic       ras_unf;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0] m_pc;
  int         m_stk[$];
  logic       m_ovf;
  logic       m_unf;

  pc_sequencer #(.PC_W(PC_W), .RESET_VEC(RESET_VEC), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .cond(cond), .offset(offset),
    .target(target), .clr_flags(clr_flags), .pc(pc), .ras_cnt(ras_cnt),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_VEC;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input bit e, input logic [2:0] o, input bit c,
                            input logic [7:0] of, input logic [7:0] tg, input bit cl);
    logic [7:0] seq;
    seq = m_pc + 8'd1;
    if (cl) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (e) begin
      case (o)
        3'd1: m_pc = c ? 8'((int'(seq) + int'($signed(of))) % 256) : seq;
        3'd2: m_pc = tg;
        3'd3: begin
          if (HAS_RAS) begin
            if (m_stk.size() < RAS_DEPTH) m_stk.push_back(int'(seq));
            else m_ovf = 1'b1;
          end
          m_pc = tg;
        end
        3'd4: begin
          if (HAS_RAS && m_stk.size() > 0) m_pc = 8'(m_stk.pop_back());
          else begin
            m_pc = seq;
            if (HAS_RAS) m_unf = 1'b1;
          end
        end
        default: m_pc = seq;
      endcase
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".cnt"}, 32'(ras_cnt), 32'(m_stk.size()));
    chk({tag, ".ovf"}, 32'(ras_ovf), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(ras_unf), 32'(m_unf));
  endtask

  task automatic step(input string tag, input bit e, input logic [2:0] o, input bit c,
                      input logic [7:0] of, input logic [7:0] tg, input bit cl);
    @(negedge clk);
    en = e; op = o; cond = c; offset = of; target = tg; clr_flags = cl;
    model_step(e, o, c, of, tg, cl);
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    chk_all("reset");
    chk("reset.pc_const", 32'(pc), 32'h10);
    @(negedge clk);
    rst = 1'b0;

    // Reset / increment / stall
    step("inc1", 1, 3'd0, 0, 8'h00, 8'h00, 0);
    step("inc2", 1, 3'd0, 0, 8'h00, 8'h00, 0);
    step("inc3", 1, 3'd0, 0, 8'h00, 8'h00, 0);
    chk("inc3.pc_const", 32'(pc), 32'h13);
    step("stall1", 0, 3'd2, 0, 8'h00, 8'h77, 0);
    step("stall2", 0, 3'd3, 0, 8'h00, 8'h55, 0);
    chk("stall.pc_const", 32'(pc), 32'h13);

    // Branch wrap and self-branch
    step("jmp_fe", 1, 3'd2, 0, 8'h00, 8'hFE, 0);
    step("br_taken", 1, 3'd1, 1, 8'h03, 8'h00, 0);
    chk("br_taken.pc_const", 32'(pc), 32'h02);
    step("jmp_fe2", 1, 3'd2, 0, 8'h00, 8'hFE, 0);
    step("br_not", 1, 3'd1, 0, 8'h03, 8'h00, 0);
    chk("br_not.pc_const", 32'(pc), 32'hFF);
    step("br_self", 1, 3'd1, 1, 8'hFF, 8'h00, 0);
    chk("br_self.pc_const", 32'(pc), 32'hFF);
    step("br_back", 1, 3'd1, 1, 8'hF0, 8'h00, 0);
    step("op_7inc", 1, 3'd7, 1, 8'h44, 8'h44, 0);

    // Nested call / return
    step("jmp_05", 1, 3'd2, 0, 8'h00, 8'h05, 0);
    step("call40", 1, 3'd3, 0, 8'h00, 8'h40, 0);
    step("call80", 1, 3'd3, 0, 8'h00, 8'h80, 0);
    step("ret1", 1, 3'd4, 0, 8'h00, 8'h00, 0);
    step("ret2", 1, 3'd4, 0, 8'h00, 8'h00, 0);
`ifdef PC_RAS_EN
    chk("ret2.pc_const", 32'(pc), 32'h06);
`else
    chk("ret2.pc_const", 32'(pc), 32'h82);
`endif

    // Overflow with depth 2, then drain and clear
    step("ovf_c1", 1, 3'd3, 0, 8'h00, 8'h30, 0);
    step("ovf_c2", 1, 3'd3, 0, 8'h00, 8'h50, 0);
    step("ovf_c3", 1, 3'd3, 0, 8'h00, 8'h70, 0);
    step("ovf_r1", 1, 3'd4, 0, 8'h00, 8'h00, 0);
    step("ovf_r2", 1, 3'd4, 0, 8'h00, 8'h00, 0);
    step("ovf_clr", 0, 3'd0, 0, 8'h00, 8'h00, 1);

    // Underflow; fault beats a simultaneous clear
    step("jmp_20", 1, 3'd2, 0, 8'h00, 8'h20, 0);
    step("unf_ret", 1, 3'd4, 0, 8'h00, 8'h00, 0);
    chk("unf_ret.pc_const", 32'(pc), 32'h21);
    step("unf_clr", 1, 3'd4, 0, 8'h00, 8'h00, 1);

    // Asynchronous reset between edges with a full stack
    step("ar_c1", 1, 3'd3, 0, 8'h00, 8'h60, 1);
    step("ar_c2", 1, 3'd3, 0, 8'h00, 8'h90, 0);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk_all("async_rst");
    chk("async_rst.pc_const", 32'(pc), 32'h10);
    #1;
    rst = 1'b0;
    step("ar_ret", 1, 3'd4, 0, 8'h00, 8'h00, 0);
    step("ar_call", 1, 3'd3, 0, 8'h00, 8'hA0, 0);
    step("ar_ret2", 1, 3'd4, 0, 8'h00, 8'h00, 0);

    // Random operations against the model
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
